// File: rtl/lfsr_period_checker.sv
// Period and bit-balance monitor for a pseudo-random stream: captures a seed word,
// counts cycles until it recurs (or a timeout window expires) and reports the result.
module lfsr_period_checker #(
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_period,
    output logic [CNT_W-1:0]  o_ones,
    output logic              o_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CYCLES);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    ones_q, ones_d;
    logic [CNT_W-1:0]    period_q, period_d;
    logic [CNT_W-1:0]    ones_out_q, ones_out_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [CNT_W-1:0]    cnt_inc_s;
    logic [CNT_W-1:0]    ones_inc_s;
    logic                match_s;

    assign cnt_inc_s  = cnt_q + CNT_ONE;
    assign ones_inc_s = ones_q + CNT_W'(i_data[0]);
    assign match_s    = (i_data == seed_q);

    // Next-state and result logic; busy/done are registered from the next state.
    always_comb begin
        state_d    = state_q;
        seed_d     = seed_q;
        cnt_d      = cnt_q;
        ones_d     = ones_q;
        period_d   = period_q;
        ones_out_d = ones_out_q;
        timeout_d  = timeout_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    seed_d     = i_data;
                    cnt_d      = CNT_ZERO;
                    ones_d     = CNT_W'(i_data[0]);
                    timeout_d  = 1'b0;
                    period_d   = CNT_ZERO;
                    ones_out_d = CNT_ZERO;
                    busy_d     = 1'b1;
                    state_d    = COUNT;
                end else begin
                    state_d    = IDLE;
                end
            end
            COUNT: begin
                // A match on the final window edge still counts as a match.
                if (match_s) begin
                    period_d   = cnt_inc_s;
                    ones_out_d = ones_q;
                    done_d     = 1'b1;
                    state_d    = DONE;
                end else if (cnt_inc_s == CNT_MAX) begin
                    timeout_d  = 1'b1;
                    period_d   = CNT_ZERO;
                    ones_out_d = ones_q;
                    done_d     = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_d      = cnt_inc_s;
                    ones_d     = ones_inc_s;
                    busy_d     = 1'b1;
                    state_d    = COUNT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            seed_q     <= {DATA_W{1'b0}};
            cnt_q      <= CNT_ZERO;
            ones_q     <= CNT_ZERO;
            period_q   <= CNT_ZERO;
            ones_out_q <= CNT_ZERO;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            seed_q     <= seed_d;
            cnt_q      <= cnt_d;
            ones_q     <= ones_d;
            period_q   <= period_d;
            ones_out_q <= ones_out_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_period  = period_q;
    assign o_ones    = ones_out_q;
    assign o_timeout = timeout_q;

endmodule
